// File: rtl/uart_rx_os.sv
// 16x oversampled UART receiver: 2-of-3 mid-bit majority voting, valid/ack output.
// Defining UART_RX_PARITY_EN adds a PARITY bit stage with parity_odd/parity_err ports.

module uart_rx_os #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 os_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam int unsigned M  = OVERSAMPLE / 2;

    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_S0   = TW'(M - 1);
    localparam logic [TW-1:0] T_S1   = TW'(M);
    localparam logic [TW-1:0] T_S2   = TW'(M + 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bitcnt_q, bitcnt_d;
    logic [1:0]             samp_q, samp_d;
    logic                   bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   stop_q, stop_d;
    logic                   brk_q, brk_d;
    logic                   deliver_q, deliver_d;
    logic [DATA_BITS-1:0]   data_d;
    logic                   valid_d, ferr_d, ovr_d, busy_d;
    logic                   vote_c;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d, perr_d;
`endif

    // Input synchronizer; resets to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs    = sync_q[SYNC_STAGES-1];
    // Third sample is taken live at count M+1 and voted with the two stored ones.
    assign vote_c = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bitcnt_d  = bitcnt_q;
        samp_d    = samp_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        stop_d    = stop_q;
        brk_d     = brk_q;
        deliver_d = 1'b0;
        data_d    = rx_data;
        valid_d   = rx_valid;
        ferr_d    = frame_err;
        ovr_d     = overrun;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = parity_err;
`endif

        if (os_tick) begin
            if (state_q != IDLE) begin
                tick_d = (tick_q == T_LAST) ? '0 : tick_q + TW'(1);
                if (tick_q == T_S0) samp_d[0] = rxs;
                if (tick_q == T_S1) samp_d[1] = rxs;
                if (tick_q == T_S2) bit_d     = vote_c;
            end
            case (state_q)
                IDLE: begin
                    // After a low stop bit the line must go high before re-arming.
                    if (brk_q) begin
                        if (rxs) brk_d = 1'b0;
                    end else if (!rxs) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == T_LAST) begin
                        if (bit_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d  = DATA;
                            bitcnt_d = '0;
                        end
                    end
                end
                DATA: begin
                    if (tick_q == T_LAST) begin
                        shreg_d = {bit_q, shreg_q[DATA_BITS-1:1]};
                        if (bitcnt_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bitcnt_d = bitcnt_q + BW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_q == T_LAST) begin
                        par_d   = bit_q;
                        state_d = STOP;
                    end
                end
`endif
                STOP: begin
                    // Leave at mid stop bit so the next start edge is caught.
                    if (tick_q == T_S2) begin
                        stop_d    = vote_c;
                        brk_d     = ~vote_c;
                        deliver_d = 1'b1;
                        state_d   = IDLE;
                        tick_d    = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Frame delivery and consumer handshake.
        if (deliver_q) begin
            if (!rx_valid || rx_ack) begin
                data_d  = shreg_q;
                ferr_d  = ~stop_q;
                valid_d = 1'b1;
                ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
                perr_d  = par_q ^ (^shreg_q) ^ parity_odd;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_valid && rx_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bitcnt_q   <= '0;
            samp_q     <= '0;
            bit_q      <= 1'b0;
            shreg_q    <= '0;
            stop_q     <= 1'b0;
            brk_q      <= 1'b0;
            deliver_q  <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bitcnt_q   <= bitcnt_d;
            samp_q     <= samp_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            stop_q     <= stop_d;
            brk_q      <= brk_d;
            deliver_q  <= deliver_d;
            rx_data    <= data_d;
            rx_valid   <= valid_d;
            frame_err  <= ferr_d;
            overrun    <= ovr_d;
            busy       <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
            parity_err <= perr_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: event-level output model checked every cycle,
// plus literal expectations. os_tick every 4 clk, 64 clk per bit.

module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       rst_n, os_tick, rx, rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_odd, parity_err, par_line, exp_perr;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_data;
    logic       exp_valid, exp_ferr, exp_ovr, exp_busy;
    logic       chk_out, chk_busy;

    uart_rx_os dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .os_tick    (os_tick),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_odd (parity_odd),
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        os_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            os_tick = 1'b1;
            @(negedge clk);
            os_tick = 1'b0;
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_out) begin
            checks++;
            if ({rx_valid, rx_data, frame_err, overrun} !== {exp_valid, exp_data, exp_ferr, exp_ovr}) begin
                errors++;
                $display("FAIL outputs t=%0t got v=%b d=%h fe=%b ov=%b expected v=%b d=%h fe=%b ov=%b",
                         $time, rx_valid, rx_data, frame_err, overrun, exp_valid, exp_data, exp_ferr, exp_ovr);
            end
`ifdef UART_RX_PARITY_EN
            checks++;
            if (parity_err !== exp_perr) begin
                errors++;
                $display("FAIL parity_err t=%0t got %b expected %b", $time, parity_err, exp_perr);
            end
`endif
        end
        if (chk_busy) begin
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy t=%0t got %b expected %b", $time, busy, exp_busy);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_lit(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        exp_busy  = 1'b0;
`ifdef UART_RX_PARITY_EN
        exp_perr  = 1'b0;
`endif
    endtask

    task automatic model_deliver(input logic [7:0] d, input logic stop_bit, input logic ack_now);
        if (!exp_valid || ack_now) begin
            exp_data  = d;
            exp_ferr  = ~stop_bit;
            exp_valid = 1'b1;
            exp_ovr   = 1'b0;
`ifdef UART_RX_PARITY_EN
            exp_perr  = par_line ^ (^d) ^ parity_odd;
`endif
        end else begin
            exp_ovr = 1'b1;
        end
    endtask

    // Called on a falling edge; returns one clock later.
    task automatic do_ack();
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        if (exp_valid) begin
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
        end
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    // mode 0: no ack, 1: ack late in the stop bit, 2: ack on the delivery cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int mode);
        int n;
        chk_busy = 1'b0;
        rx = 1'b0;
        wait_clk(8);
        exp_busy = 1'b1;
        chk_busy = 1'b1;
        wait_clk(56);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(64);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_line;
        wait_clk(64);
`endif
        rx = stop_bit;
        wait_clk(24);
        chk_out  = 1'b0;
        chk_busy = 1'b0;
        if (mode == 2) begin
            n = 24;
            while (busy && n < 60) begin
                wait_clk(1);
                n++;
            end
            checks++;
            if (busy) begin
                errors++;
                $display("FAIL stop_timeout: busy got 1 expected 0 within stop bit");
            end
            rx_ack = 1'b1;
            wait_clk(1);
            rx_ack = 1'b0;
            n++;
            if (n < 56) wait_clk(56 - n);
        end else begin
            wait_clk(32);
        end
        model_deliver(d, stop_bit, mode == 2);
        exp_busy = 1'b0;
        chk_out  = 1'b1;
        chk_busy = 1'b1;
        wait_clk(2);
        if (mode == 1) begin
            do_ack();
            wait_clk(5);
        end else begin
            wait_clk(6);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ack   = 1'b0;
        chk_out  = 1'b0;
        chk_busy = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        par_line   = 1'b0;
`endif
        model_reset();
        wait_clk(3);
        check_lit("reset_data", 16'(rx_data), 16'h0000);
        check_lit("reset_flags", 16'({rx_valid, frame_err, overrun, busy}), 16'h0000);
        rst_n = 1'b1;
        chk_out  = 1'b1;
        chk_busy = 1'b1;
        wait_clk(64);

        // Nominal byte, held until ack.
        send_frame(8'hA5, 1'b1, 0);
        wait_clk(100);
        check_lit("nominal_data", 16'(rx_data), 16'h00A5);
        check_lit("nominal_flags", 16'({rx_valid, frame_err, overrun, busy}), 16'h0008);
        do_ack();
        check_lit("nominal_ack", 16'(rx_valid), 16'h0000);
        wait_clk(64);

        // Start glitch of 3 os_ticks.
        chk_busy = 1'b0;
        rx = 1'b0;
        wait_clk(8);
        exp_busy = 1'b1;
        chk_busy = 1'b1;
        wait_clk(4);
        rx = 1'b1;
        wait_clk(48);
        chk_busy = 1'b0;
        wait_clk(14);
        exp_busy = 1'b0;
        chk_busy = 1'b1;
        wait_clk(64);
        check_lit("glitch_valid", 16'(rx_valid), 16'h0000);

        // Framing error, then a clean frame.
        send_frame(8'h3C, 1'b0, 0);
        rx = 1'b1;
        wait_clk(64);
        check_lit("frame_data", 16'(rx_data), 16'h003C);
        check_lit("frame_err_set", 16'(frame_err), 16'h0001);
        do_ack();
        send_frame(8'h55, 1'b1, 0);
        check_lit("frame_err_clr", 16'({rx_data, frame_err}), 16'h00AA);
        do_ack();

        // Overrun, then delivery with simultaneous ack.
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        check_lit("ovr_data", 16'(rx_data), 16'h0011);
        check_lit("ovr_flags", 16'({rx_valid, overrun}), 16'h0003);
        do_ack();
        check_lit("ovr_cleared", 16'({rx_valid, overrun}), 16'h0000);
        wait_clk(64);
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 2);
        check_lit("simack_data", 16'(rx_data), 16'h0022);
        check_lit("simack_flags", 16'({rx_valid, overrun}), 16'h0002);
        do_ack();

        // Break: line held low well past the frame.
        send_frame(8'h00, 1'b0, 0);
        wait_clk(320);
        check_lit("break_flags", 16'({rx_valid, frame_err, busy}), 16'h0006);
        rx = 1'b1;
        wait_clk(64);
        do_ack();
        wait_clk(64);

        // Back-to-back frames, then reset in mid DATA.
        send_frame(8'h00, 1'b1, 1);
        send_frame(8'hFF, 1'b1, 1);
        send_frame(8'h81, 1'b1, 1);
        check_lit("b2b_data", 16'(rx_data), 16'h0081);
        chk_busy = 1'b0;
        rx = 1'b0;
        wait_clk(8);
        exp_busy = 1'b1;
        chk_busy = 1'b1;
        wait_clk(56);
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            wait_clk(64);
        end
        wait_clk(20);
        chk_out  = 1'b0;
        chk_busy = 1'b0;
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        model_reset();
        check_lit("midrst_data", 16'(rx_data), 16'h0000);
        check_lit("midrst_flags", 16'({rx_valid, frame_err, overrun, busy}), 16'h0000);
        wait_clk(1);
        chk_out  = 1'b1;
        chk_busy = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(64);
        send_frame(8'h7E, 1'b1, 0);
        check_lit("post_rst_data", 16'({rx_valid, rx_data}), 16'h017E);
        do_ack();

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1.
        par_line = 1'b1;
        send_frame(8'h07, 1'b1, 1);
        check_lit("parity_ok", 16'(parity_err), 16'h0000);
        par_line = 1'b0;
        send_frame(8'h07, 1'b1, 1);
        check_lit("parity_bad", 16'(parity_err), 16'h0001);
`endif

        wait_clk(64);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
